// File: rtl/apb_rr_requester_arbiter.sv
// Round-robin arbiter sharing one APB requester port among NUM_REQ clients.
// Ports: PCLK/PRESET (sync, active-high); req_* packed client commands with
//   one-hot req_ready; rsp_valid (one-hot pulse) with rsp_rdata/rsp_error;
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT out, PRDATA/PREADY/PSLVERR in.
module apb_rr_requester_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]       req_prot,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_error,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic [ADDR_W-1:0]          PADDR,
  output logic                       PWRITE,
  output logic [DATA_W-1:0]          PWDATA,
  output logic [DATA_W/8-1:0]        PSTRB,
  output logic [2:0]                 PPROT,
  input  logic [DATA_W-1:0]          PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);

  localparam int SW = DATA_W / 8;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] owner;
  logic          found;
  logic          accept;
  logic          done;
  logic          abort;
  logic          timed_out;
  logic [CW-1:0] wcnt;

  // First valid client after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // This ACCESS cycle is the TIMEOUT-th one without PREADY.
  assign timed_out = (TIMEOUT != 0) && (wcnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !PRESET) begin
          accept         = 1'b1;
          req_ready[win] = 1'b1;
          state_nx       = SETUP;
        end
      end
      SETUP: begin
        PSEL     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (timed_out) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr       <= IW'(NUM_REQ - 1);
      owner     <= '0;
      wcnt      <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      if (accept) begin
        ptr    <= win;
        owner  <= win;
        wcnt   <= '0;
        PWRITE <= req_write[win];
        PADDR  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        PWDATA <= req_wdata[int'(win)*DATA_W +: DATA_W];
        PPROT  <= req_prot[int'(win)*3 +: 3];
        // Reads never carry strobes.
        PSTRB  <= req_write[win] ? req_strb[int'(win)*SW +: SW] : '0;
      end
      if (state == ACCESS && !PREADY) wcnt <= wcnt + CW'(1);
      if (done) begin
        rsp_valid[owner] <= 1'b1;
        rsp_rdata        <= PWRITE ? '0 : PRDATA;
        rsp_error        <= PSLVERR;
      end
      if (abort) begin
        rsp_valid[owner] <= 1'b1;
        rsp_error        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_requester_arbiter.sv
// Bench for apb_rr_requester_arbiter: directed scenarios plus random traffic
// against a transaction-level model of grants, bus phases and responses.
module tb_apb_rr_requester_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*SW-1:0]   req_strb;
  logic [N*3-1:0]    req_prot;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_error;
  logic              PSEL;
  logic              PENABLE;
  logic [AW-1:0]     PADDR;
  logic              PWRITE;
  logic [DW-1:0]     PWDATA;
  logic [SW-1:0]     PSTRB;
  logic [2:0]        PPROT;
  logic [DW-1:0]     PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  apb_rr_requester_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // client-side command registers
  bit          cv[N];
  bit          cw[N];
  logic [AW-1:0] ca[N];
  logic [DW-1:0] cd[N];
  logic [SW-1:0] cs[N];
  logic [2:0]    cp[N];

  task automatic drive_clients();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = cv[i];
      req_write[i]          = cw[i];
      req_addr[i*AW +: AW]  = ca[i];
      req_wdata[i*DW +: DW] = cd[i];
      req_strb[i*SW +: SW]  = cs[i];
      req_prot[i*3 +: 3]    = cp[i];
    end
  endtask

  task automatic newcmd(input int i);
    cw[i] = 1'($urandom_range(0, 1));
    ca[i] = $urandom;
    cd[i] = $urandom;
    cs[i] = SW'($urandom_range(0, 15));
    cp[i] = 3'($urandom_range(0, 7));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // transaction-level model: one transfer in flight, aged in cycles
  int          m_ptr = N - 1;
  bit          m_busy = 1'b0;
  int          m_owner = 0;
  int          m_age = 0;
  int          m_wait = 0;
  bit          m_w = 1'b0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0;
  logic [SW-1:0] m_s = '0;
  logic [2:0]    m_p = '0;
  bit          m_rsp = 1'b0;
  int          m_rsp_own = 0;
  logic [DW-1:0] m_rsp_data = '0;
  bit          m_rsp_err = 1'b0;
  logic [N-1:0]  acc_q = '0;
  logic [N-1:0]  er;
  int          w;
  int          idx;
  bit          nr;

  always @(posedge clk) begin
    #4;
    er = '0;
    w  = -1;
    if (!m_busy && !rst) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", req_ready, er);
    check("psel", PSEL, m_busy);
    check("penable", PENABLE, m_busy && m_age >= 2);
    check("paddr", PADDR, m_a);
    check("pwrite", PWRITE, m_w);
    check("pwdata", PWDATA, m_d);
    check("pstrb", PSTRB, m_s);
    check("pprot", PPROT, m_p);
    check("rsp_valid", rsp_valid, m_rsp ? (1 << m_rsp_own) : 0);
    if (m_rsp) begin
      check("rsp_rdata", rsp_rdata, m_rsp_data);
      check("rsp_error", rsp_error, m_rsp_err);
    end
    acc_q = er;
    if (rst) begin
      m_ptr  = N - 1;
      m_busy = 1'b0;
      m_rsp  = 1'b0;
      m_w    = 1'b0;
      m_a    = '0;
      m_d    = '0;
      m_s    = '0;
      m_p    = '0;
    end else begin
      nr = 1'b0;
      if (m_busy) begin
        if (m_age == 1) begin
          m_age = 2;
        end else if (PREADY) begin
          nr         = 1'b1;
          m_rsp_own  = m_owner;
          m_rsp_data = m_w ? '0 : PRDATA;
          m_rsp_err  = PSLVERR;
          m_busy     = 1'b0;
        end else begin
          m_wait++;
          if (TO != 0 && m_wait == TO) begin
            nr         = 1'b1;
            m_rsp_own  = m_owner;
            m_rsp_data = '0;
            m_rsp_err  = 1'b1;
            m_busy     = 1'b0;
          end else begin
            m_age++;
          end
        end
      end else if (w >= 0) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_wait  = 0;
        m_owner = w;
        m_ptr   = w;
        m_w     = req_write[w];
        m_a     = req_addr[w*AW +: AW];
        m_d     = req_wdata[w*DW +: DW];
        m_p     = req_prot[w*3 +: 3];
        m_s     = m_w ? req_strb[w*SW +: SW] : '0;
      end
      m_rsp = nr;
    end
  end

  logic [N-1:0] rr_exp[5];
  int stuck;

  initial begin
    rst     = 1'b1;
    PREADY  = 1'b0;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    for (int i = 0; i < N; i++) begin
      cv[i] = 0; cw[i] = 0; ca[i] = '0;
      cd[i] = '0; cs[i] = '0; cp[i] = '0;
    end
    drive_clients();
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_paddr", PADDR, 0);

    // single write, zero wait
    tick();
    cv[0] = 1; cw[0] = 1; ca[0] = 32'h10;
    cd[0] = 32'hDEADBEEF; cs[0] = 4'hF; cp[0] = 3'd0;
    PREADY = 1'b1;
    drive_clients();
    settle();
    check("t1_ready", req_ready, 4'b0001);
    tick();
    cv[0] = 0;
    drive_clients();
    settle();
    check("t1_setup_sel", {PSEL, PENABLE}, 2'b10);
    check("t1_paddr", PADDR, 32'h10);
    check("t1_pwdata", PWDATA, 32'hDEADBEEF);
    check("t1_pstrb", PSTRB, 4'hF);
    tick();
    settle();
    check("t1_access", {PSEL, PENABLE}, 2'b11);
    tick();
    settle();
    check("t1_rsp", rsp_valid, 4'b0001);
    check("t1_err", rsp_error, 0);
    check("t1_idle", PSEL, 0);

    // read with three wait states
    tick();
    cv[2] = 1; cw[2] = 0; ca[2] = 32'h20;
    cs[2] = 4'hF; cp[2] = 3'b101;
    PREADY = 1'b0;
    drive_clients();
    settle();
    check("t2_ready", req_ready, 4'b0100);
    tick();
    cv[2] = 0;
    drive_clients();
    settle();
    check("t2_pstrb", PSTRB, 0);
    check("t2_paddr", PADDR, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      check("t2_wait", PENABLE, 1);
    end
    tick();
    PREADY = 1'b1;
    PRDATA = 32'h1234;
    settle();
    check("t2_access4", PENABLE, 1);
    tick();
    PREADY = 1'b0;
    settle();
    check("t2_rsp", rsp_valid, 4'b0100);
    check("t2_rdata", rsp_rdata, 32'h1234);

    // all clients valid: rotation from reset
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      cv[i] = 1; newcmd(i);
    end
    PREADY = 1'b1;
    drive_clients();
    settle();
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;
    for (int g = 0; g < 5; g++) begin
      check("t3_grant", req_ready, rr_exp[g]);
      if (g > 0) check("t3_rsp", rsp_valid, rr_exp[g-1]);
      tick();
      settle();
      check("t3_setup", req_ready, 0);
      tick();
      settle();
      check("t3_access", req_ready, 0);
      tick();
      settle();
    end
    check("t3_rsp_last", rsp_valid, rr_exp[4]);

    // timeout abort, then next client served
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) cv[i] = 0;
    drive_clients();
    tick();
    rst = 1'b0;
    cv[1] = 1; cw[1] = 0; ca[1] = 32'h40; cs[1] = 4'h0;
    cv[3] = 1; cw[3] = 1; ca[3] = 32'h80;
    cd[3] = 32'hA5A5; cs[3] = 4'h3;
    PREADY = 1'b0;
    PRDATA = 32'hFFFFFFFF;
    drive_clients();
    settle();
    check("t4_ready", req_ready, 4'b0010);
    tick();
    cv[1] = 0;
    drive_clients();
    settle();
    check("t4_setup", {PSEL, PENABLE}, 2'b10);
    for (int i = 0; i < TO; i++) begin
      tick();
      settle();
      check("t4_wait", PENABLE, 1);
    end
    tick();
    settle();
    check("t4_rsp", rsp_valid, 4'b0010);
    check("t4_err", rsp_error, 1);
    check("t4_rdata", rsp_rdata, 0);
    check("t4_psel", PSEL, 0);
    check("t4_next", req_ready, 4'b1000);

    // slave error on a write
    tick();
    cv[3] = 0;
    PREADY = 1'b1;
    PSLVERR = 1'b1;
    drive_clients();
    settle();
    tick();
    settle();
    check("t5_pstrb", PSTRB, 4'h3);
    tick();
    PSLVERR = 1'b0;
    settle();
    check("t5_rsp", rsp_valid, 4'b1000);
    check("t5_err", rsp_error, 1);
    tick();
    cv[0] = 1; cw[0] = 1; ca[0] = 32'h4;
    cd[0] = 32'h55; cs[0] = 4'h1;
    drive_clients();
    settle();
    check("t5_ready0", req_ready, 4'b0001);
    tick();
    cv[0] = 0;
    drive_clients();
    tick();
    tick();
    settle();
    check("t5_rsp0", rsp_valid, 4'b0001);
    check("t5_err0", rsp_error, 0);

    // reset during ACCESS
    tick();
    cv[2] = 1; cw[2] = 0; ca[2] = 32'h60;
    PREADY = 1'b0;
    drive_clients();
    settle();
    check("t6_ready", req_ready, 4'b0100);
    tick();
    cv[2] = 0;
    drive_clients();
    tick();
    rst = 1'b1;
    settle();
    check("t6_access", PENABLE, 1);
    tick();
    rst = 1'b0;
    cv[0] = 1; cw[0] = 1; ca[0] = 32'h8;
    cv[3] = 1;
    drive_clients();
    settle();
    check("t6_sel", {PSEL, PENABLE}, 2'b00);
    check("t6_norsp", rsp_valid, 0);
    check("t6_ready0", req_ready, 4'b0001);
    tick();
    cv[0] = 0;
    drive_clients();
    settle();
    check("t6_norsp2", rsp_valid, 0);

    // random traffic
    stuck = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      if (stuck > 0) stuck--;
      else if ($urandom_range(0, 199) == 0) stuck = 40;
      PREADY  = (stuck > 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
      PRDATA  = $urandom;
      PSLVERR = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (cv[i] && acc_q[i]) begin
          cv[i] = 1'($urandom_range(0, 1));
          if (cv[i]) newcmd(i);
        end else if (cv[i]) begin
          if ($urandom_range(0, 19) == 0) cv[i] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          cv[i] = 1;
          newcmd(i);
        end
      end
      drive_clients();
    end
    tick();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
